vproc_bus_arbiter: RTL and testbench

//  Shares one slave memory/peripheral bus between NUM_MASTERS VProc instances using round-robin arbitration.

---
 rtl/vproc_bus_arbiter_pkg.sv | 23 ++
 rtl/vproc_bus_arbiter_if.sv | 38 +++
 rtl/vproc_rr_pick.sv | 32 +++
 rtl/vproc_bus_arbiter.sv | 171 +++++++++++++++++
 tb/tb_vproc_bus_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vproc_bus_arbiter_pkg.sv
// Shared types for the VProc bus arbiter: FSM states, the latched
// transaction record and the timeout counter sizing helper.
package vproc_bus_arbiter_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wr;
  } arb_txn_t;

  function automatic int tmo_cnt_w(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/vproc_bus_arbiter_if.sv
// Bus bundle between the VProc array, the arbiter and the shared slave.
// arb is the arbiter's view; master/slave are the two far ends.
interface vproc_bus_arbiter_if
  import vproc_bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4
) ();

  logic [DATA_W*NUM_MASTERS-1:0] MAddr;
  logic [NUM_MASTERS-1:0]        MWE;
  logic [NUM_MASTERS-1:0]        MRD;
  logic [DATA_W*NUM_MASTERS-1:0] MDataOut;
  logic [DATA_W-1:0]             MDataIn;
  logic [NUM_MASTERS-1:0]        MWRAck;
  logic [NUM_MASTERS-1:0]        MRDAck;
  logic [DATA_W-1:0]             SAddr;
  logic                          SWE;
  logic                          SRD;
  logic [DATA_W-1:0]             SDataOut;
  logic [DATA_W-1:0]             SDataIn;
  logic                          SAck;

  modport arb (
    input  MAddr, MWE, MRD, MDataOut, SDataIn, SAck,
    output MDataIn, MWRAck, MRDAck, SAddr, SWE, SRD, SDataOut
  );

  modport master (
    output MAddr, MWE, MRD, MDataOut,
    input  MDataIn, MWRAck, MRDAck
  );

  modport slave (
    input  SAddr, SWE, SRD, SDataOut,
    output SDataIn, SAck
  );

endinterface

// File: rtl/vproc_rr_pick.sv
// Combinational round-robin picker: first requester strictly after 'last',
// wrapping modulo NUM_REQ. Also used for multi-VProc interrupt arbitration.
module vproc_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int  c;
    logic found;
    gnt   = '0;
    idx   = '0;
    any   = |req;
    found = 1'b0;
    c     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      c = (int'(last) + k) % NUM_REQ;
      if (!found && req[c]) begin
        found  = 1'b1;
        gnt[c] = 1'b1;
        idx    = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/vproc_bus_arbiter.sv
// Round-robin arbiter sharing one slave bus between NUM_MASTERS VProcs,
// with registered strobes/acks and an optional hung-slave timeout.
module vproc_bus_arbiter
  import vproc_bus_arbiter_pkg::*;
#(
  parameter int                NUM_MASTERS  = 4,
  parameter int                MIDX_W       = 2,
  parameter int                TIMEOUT      = 256,
  parameter logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic                   Clk,
  input  logic                   nReset,
  vproc_bus_arbiter_if.arb       bus,
  output logic [NUM_MASTERS-1:0] Grant,
  output logic                   Busy,
  output logic                   ErrTimeout,
  output logic [MIDX_W-1:0]      ErrMaster
);

  arb_state_e             state_q, state_d;
  logic [MIDX_W-1:0]      ptr_q, ptr_d;
  logic [MIDX_W-1:0]      pick_idx;
  logic [NUM_MASTERS-1:0] req, pick_gnt;
  logic                   pick_any;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [NUM_MASTERS-1:0] wr_ack_q, wr_ack_d;
  logic [NUM_MASTERS-1:0] rd_ack_q, rd_ack_d;
  arb_txn_t               txn_q, txn_d;
  logic                   swe_q, swe_d, srd_q, srd_d;
  logic                   busy_q, busy_d;
  logic                   err_q, err_d;
  logic [MIDX_W-1:0]      errm_q, errm_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   tmo_exp;

  assign req = bus.MWE | bus.MRD;

  vproc_rr_pick #(
    .NUM_REQ (NUM_MASTERS),
    .IDX_W   (MIDX_W)
  ) u_pick (
    .req  (req),
    .last (ptr_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Counter is loaded on the grant edge; expiry is the edge it reads 1.
  generate
    if (TIMEOUT != 0) begin : g_tmo
      localparam int CNT_W = tmo_cnt_w(TIMEOUT);
      logic [CNT_W-1:0] cnt_q;

      always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
          cnt_q <= '0;
        end else if (state_q == ST_IDLE && pick_any) begin
          cnt_q <= CNT_W'(TIMEOUT);
        end else if (state_q == ST_GRANT) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end

      assign tmo_exp = (cnt_q == CNT_W'(1));
    end else begin : g_no_tmo
      assign tmo_exp = 1'b0;
    end
  endgenerate

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= MIDX_W'(NUM_MASTERS - 1);
      grant_q  <= '0;
      wr_ack_q <= '0;
      rd_ack_q <= '0;
      txn_q    <= '0;
      swe_q    <= 1'b0;
      srd_q    <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
      errm_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      wr_ack_q <= wr_ack_d;
      rd_ack_q <= rd_ack_d;
      txn_q    <= txn_d;
      swe_q    <= swe_d;
      srd_q    <= srd_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
      errm_q   <= errm_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    wr_ack_d = wr_ack_q;
    rd_ack_d = rd_ack_q;
    txn_d    = txn_q;
    swe_d    = swe_q;
    srd_d    = srd_q;
    err_d    = err_q;
    errm_d   = errm_q;
    rdata_d  = rdata_q;

    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d     = ST_GRANT;
          ptr_d       = pick_idx;
          grant_d     = pick_gnt;
          txn_d.addr  = bus.MAddr[DATA_W*int'(pick_idx) +: DATA_W];
          txn_d.wdata = bus.MDataOut[DATA_W*int'(pick_idx) +: DATA_W];
          // Write takes precedence when a master raises both WE and RD.
          txn_d.wr    = bus.MWE[pick_idx];
          swe_d       = bus.MWE[pick_idx];
          srd_d       = !bus.MWE[pick_idx];
        end
      end
      ST_GRANT: begin
        if (bus.SAck || tmo_exp) begin
          state_d = ST_RESP;
          swe_d   = 1'b0;
          srd_d   = 1'b0;
          if (txn_q.wr) begin
            wr_ack_d = grant_q;
          end else begin
            rd_ack_d = grant_q;
            rdata_d  = bus.SAck ? bus.SDataIn : TIMEOUT_DATA;
          end
          if (!bus.SAck) begin
            err_d = 1'b1;
            if (!err_q) errm_d = ptr_q;
          end
        end
      end
      ST_RESP: begin
        state_d  = ST_IDLE;
        grant_d  = '0;
        wr_ack_d = '0;
        rd_ack_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  assign Grant        = grant_q;
  assign Busy         = busy_q;
  assign ErrTimeout   = err_q;
  assign ErrMaster    = errm_q;
  assign bus.SAddr    = txn_q.addr;
  assign bus.SDataOut = txn_q.wdata;
  assign bus.SWE      = swe_q;
  assign bus.SRD      = srd_q;
  assign bus.MDataIn  = rdata_q;
  assign bus.MWRAck   = wr_ack_q;
  assign bus.MRDAck   = rd_ack_q;

endmodule

// File: tb/tb_vproc_bus_arbiter.sv
// Bench for vproc_bus_arbiter: directed scenarios followed by random traffic,
// checked per transaction against a round-robin/timeout reference model.
module tb_vproc_bus_arbiter;

  localparam int          N     = 4;
  localparam int          MW    = 2;
  localparam int          TMO   = 8;
  localparam logic [31:0] TDATA = 32'hDEADBEEF;

  logic          Clk = 1'b0;
  logic          nReset = 1'b0;
  logic [N-1:0]  Grant;
  logic          Busy;
  logic          ErrTimeout;
  logic [MW-1:0] ErrMaster;

  logic [N-1:0]  m_we, m_rd;
  logic [31:0]   m_addr [N];
  logic [31:0]   m_data [N];
  logic          sack;
  logic [31:0]   sdata;

  int            vectors = 0;
  int            errors  = 0;
  int            cyc     = 0;
  int            ptr_m;
  bit            err_m;
  int            errm_m;
  logic [31:0]   rdata_m;
  int            last_win;
  int            last_grant_cyc;

  vproc_bus_arbiter_if #(.NUM_MASTERS(N)) bus ();

  assign bus.MWE     = m_we;
  assign bus.MRD     = m_rd;
  assign bus.SAck    = sack;
  assign bus.SDataIn = sdata;

  for (genvar i = 0; i < N; i++) begin : g_m
    assign bus.MAddr[32*i +: 32]    = m_addr[i];
    assign bus.MDataOut[32*i +: 32] = m_data[i];
  end

  vproc_bus_arbiter #(
    .NUM_MASTERS  (N),
    .MIDX_W       (MW),
    .TIMEOUT      (TMO),
    .TIMEOUT_DATA (TDATA)
  ) dut (
    .Clk        (Clk),
    .nReset     (nReset),
    .bus        (bus),
    .Grant      (Grant),
    .Busy       (Busy),
    .ErrTimeout (ErrTimeout),
    .ErrMaster  (ErrMaster)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  // Reference round-robin: first requesting master after 'last', modulo N.
  function automatic int rr_winner(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  // kind: 0 idle, 1 write, 2 read, 3 write+read
  task automatic set_req(input int m, input int kind);
    m_we[m]   = (kind == 1 || kind == 3);
    m_rd[m]   = (kind == 2 || kind == 3);
    m_addr[m] = $urandom;
    m_data[m] = $urandom;
  endtask

  // One full arbitration: slave acks after w wait cycles with sd.
  // Entered with the DUT idle and requests already driven.
  task automatic run_one(input int w, input logic [31:0] sd);
    int          win, c, exp_g;
    bit          wr, tmo, held;
    logic [31:0] a, d;
    win = rr_winner(m_we | m_rd, ptr_m);
    if (win < 0) begin
      vectors++;
      errors++;
      $error("FAIL run_one: no master requesting");
      return;
    end
    wr = m_we[win];
    a  = m_addr[win];
    d  = m_data[win];
    c  = 0;
    do begin
      @(negedge Clk);
      c++;
    end while (Grant == '0 && c < 4);
    chk("grant_latency", c, 1);
    chk("grant_onehot", Grant, 32'd1 << win);
    chk("swe", bus.SWE, wr);
    chk("srd", bus.SRD, !wr);
    chk("saddr", bus.SAddr, a);
    chk("sdataout", bus.SDataOut, d);
    chk("busy_grant", Busy, 1);
    chk("ack_early", bus.MWRAck | bus.MRDAck, 0);
    last_win       = win;
    last_grant_cyc = cyc;
    ptr_m          = win;

    tmo   = (w >= TMO);
    exp_g = tmo ? TMO : w + 1;
    sdata = sd;
    held  = 1'b1;
    c     = 0;
    while (1) begin
      sack = (c == w);
      @(negedge Clk);
      c++;
      if ((bus.MWRAck | bus.MRDAck) != '0 || c >= TMO + 4) break;
      if (bus.SWE !== wr || bus.SRD !== !wr || bus.SAddr !== a) held = 1'b0;
    end
    sack = 1'b0;

    if (!wr) rdata_m = tmo ? TDATA : sd;
    if (tmo) begin
      if (!err_m) errm_m = win;
      err_m = 1'b1;
    end
    chk("grant_cycles", c, exp_g);
    chk("strobes_held", held, 1);
    chk("wrack", bus.MWRAck, wr ? (32'd1 << win) : 32'd0);
    chk("rdack", bus.MRDAck, wr ? 32'd0 : (32'd1 << win));
    chk("mdatain", bus.MDataIn, rdata_m);
    chk("grant_resp", Grant, 32'd1 << win);
    chk("strobes_resp", {bus.SWE, bus.SRD}, 0);
    chk("err_timeout", ErrTimeout, err_m);
    chk("err_master", ErrMaster, errm_m);

    @(negedge Clk);
    chk("grant_idle", Grant, 0);
    chk("ack_idle", bus.MWRAck | bus.MRDAck, 0);
    chk("busy_idle", Busy, 0);
    chk("mdatain_hold", bus.MDataIn, rdata_m);
  endtask

  task automatic model_reset();
    ptr_m   = N - 1;
    err_m   = 1'b0;
    errm_m  = 0;
    rdata_m = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, Grant, 0);
    chk({tag, "_busy"}, Busy, 0);
    chk({tag, "_strobes"}, {bus.SWE, bus.SRD}, 0);
    chk({tag, "_saddr"}, bus.SAddr, 0);
    chk({tag, "_sdataout"}, bus.SDataOut, 0);
    chk({tag, "_acks"}, {bus.MWRAck, bus.MRDAck}, 0);
    chk({tag, "_mdatain"}, bus.MDataIn, 0);
    chk({tag, "_err"}, {ErrTimeout, ErrMaster}, 0);
  endtask

  initial begin
    int c, pc;
    m_we  = '0;
    m_rd  = '0;
    sack  = 1'b0;
    sdata = '0;
    for (int i = 0; i < N; i++) begin
      m_addr[i] = '0;
      m_data[i] = '0;
    end
    model_reset();

    // Reset values
    #3;
    chk_all_zero("reset");
    repeat (2) @(negedge Clk);
    nReset = 1'b1;

    // All four masters write together, slave acks immediately
    for (int i = 0; i < N; i++) set_req(i, 1);
    for (int t = 0; t < 5; t++) begin
      pc = last_grant_cyc;
      run_one(0, $urandom);
      chk("t2_order", last_win, t % N);
      if (t > 0) chk("t2_period", last_grant_cyc - pc, 3);
      set_req(last_win, 1);
    end
    m_we = '0;

    // Single read from M1 with two slave wait cycles
    set_req(1, 2);
    m_addr[1] = 32'h100;
    run_one(2, 32'h12345678);
    chk("t1_rdata", bus.MDataIn, 32'h12345678);
    m_rd = '0;

    // WE and RD both high: treated as a write
    set_req(0, 3);
    run_one(1, $urandom);
    m_we = '0;
    m_rd = '0;

    // SAck arrives on the expiry edge: normal completion
    set_req(2, 2);
    run_one(TMO - 1, 32'hCAFEF00D);
    chk("t6_no_err", ErrTimeout, 0);
    m_rd = '0;

    // Timeouts: first on M2, second on M3 leaves ErrMaster at 2
    set_req(2, 2);
    run_one(100, $urandom);
    m_rd = '0;
    chk("t3_err_first", {ErrTimeout, ErrMaster}, {1'b1, 2'd2});
    set_req(3, 2);
    run_one(100, $urandom);
    m_rd = '0;
    chk("t3_err_sticky", {ErrTimeout, ErrMaster}, {1'b1, 2'd2});

    // Reset during GRANT aborts, then pointer restarts at master 0
    set_req(1, 2);
    c = 0;
    do begin
      @(negedge Clk);
      c++;
    end while (Grant == '0 && c < 4);
    chk("t5_pre_grant", Grant, 32'd2);
    chk("t5_pre_srd", bus.SRD, 1);
    repeat (2) @(negedge Clk);
    #2 nReset = 1'b0;
    #1;
    chk_all_zero("t5_async");
    model_reset();
    m_rd = '0;
    set_req(0, 1);
    set_req(3, 1);
    @(negedge Clk);
    chk_all_zero("t5_held");
    nReset = 1'b1;
    run_one(0, $urandom);
    chk("t5_first_grant", last_win, 0);
    set_req(0, 0);

    // Random traffic; master 3 is still requesting from above
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) begin
        if (!m_we[i] && !m_rd[i] && $urandom_range(0, 2) == 0) set_req(i, $urandom_range(1, 3));
      end
      if ((m_we | m_rd) == '0) set_req($urandom_range(0, N - 1), $urandom_range(1, 3));
      run_one($urandom_range(0, 10), $urandom);
      set_req(last_win, $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
